// File: rtl/lfsr_rng_arbiter_if.sv
// Request/delivery bundle between random-byte consumers
// and the shared LFSR arbiter.
interface lfsr_rng_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic         seed_load;
  logic [7:0]   seed_data;
  logic [N-1:0] grant;
  logic [7:0]   rand_data;
  logic         rand_valid;
  logic         busy;
  logic         seed_ready;

  modport master (
    output req,
    output seed_load,
    output seed_data,
    input  grant,
    input  rand_data,
    input  rand_valid,
    input  busy,
    input  seed_ready
  );

  modport slave (
    input  req,
    input  seed_load,
    input  seed_data,
    output grant,
    output rand_data,
    output rand_valid,
    output busy,
    output seed_ready
  );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 8-bit Fibonacci LFSR;
// each grant advances the LFSR STEPS times before delivery.
module lfsr_rng_arbiter #(
  parameter int N     = 4,
  parameter int STEPS = 8
) (
  input  logic clk,
  input  logic reset,
  lfsr_rng_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADVANCE,
    DELIVER
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_n;
  logic [7:0]    lfsr_shift;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_n;
  logic [PW-1:0] win;
  logic [PW-1:0] win_q;
  logic [PW-1:0] win_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          found;
  logic [N-1:0]  grant_n;
  logic [7:0]    data_n;
  int            idx;

  assign lfsr_shift = {
    lfsr[4] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0],
    lfsr[7:1]
  };

  // First requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    ptr_n   = ptr;
    win_n   = win_q;
    cnt_n   = cnt;
    grant_n = '0;
    data_n  = bus.rand_data;
    unique case (state)
      IDLE: begin
        if (bus.seed_load) begin
          // Zero would lock the LFSR up.
          lfsr_n = (bus.seed_data == 8'h00)
                 ? 8'hFF : bus.seed_data;
        end else if (found) begin
          win_n   = win;
          cnt_n   = '0;
          state_n = ADVANCE;
        end
      end
      ADVANCE: begin
        lfsr_n = lfsr_shift;
        cnt_n  = cnt + 1'b1;
        if (cnt == CW'(STEPS - 1)) begin
          state_n = DELIVER;
          data_n  = lfsr_shift;
          for (int i = 0; i < N; i++) begin
            grant_n[i] = (PW'(i) == win_q);
          end
        end
      end
      DELIVER: begin
        state_n = IDLE;
        ptr_n   = PW'((int'(win_q) + 1) % N);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      lfsr           <= 8'hFF;
      ptr            <= '0;
      win_q          <= '0;
      cnt            <= '0;
      bus.grant      <= '0;
      bus.rand_data  <= 8'h00;
      bus.rand_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.seed_ready <= 1'b1;
    end else begin
      state          <= state_n;
      lfsr           <= lfsr_n;
      ptr            <= ptr_n;
      win_q          <= win_n;
      cnt            <= cnt_n;
      bus.grant      <= grant_n;
      bus.rand_data  <= data_n;
      bus.rand_valid <= (state_n == DELIVER);
      bus.busy       <= (state_n != IDLE);
      bus.seed_ready <= (state_n == IDLE);
    end
  end
endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: STEPS=8 and STEPS=1 instances
// checked each cycle against a transaction-level model.
module tb_lfsr_rng_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lfsr_rng_arbiter_if #(.N(4)) b8 ();
  lfsr_rng_arbiter_if #(.N(4)) b1 ();

  lfsr_rng_arbiter #(.N(4), .STEPS(8)) u8 (
    .clk(clk), .reset(rst_n), .bus(b8)
  );
  lfsr_rng_arbiter #(.N(4), .STEPS(1)) u1 (
    .clk(clk), .reset(rst_n), .bus(b1)
  );

  int errs = 0;
  int checks = 0;

  logic [3:0] a_grant [2];
  logic [7:0] a_data  [2];
  logic       a_valid [2];
  logic       a_busy  [2];
  logic       a_ready [2];
  logic [3:0] in_req  [2];
  logic       in_seed [2];
  logic [7:0] in_sd   [2];

  assign a_grant[0] = b8.grant;
  assign a_grant[1] = b1.grant;
  assign a_data[0]  = b8.rand_data;
  assign a_data[1]  = b1.rand_data;
  assign a_valid[0] = b8.rand_valid;
  assign a_valid[1] = b1.rand_valid;
  assign a_busy[0]  = b8.busy;
  assign a_busy[1]  = b1.busy;
  assign a_ready[0] = b8.seed_ready;
  assign a_ready[1] = b1.seed_ready;
  assign in_req[0]  = b8.req;
  assign in_req[1]  = b1.req;
  assign in_seed[0] = b8.seed_load;
  assign in_seed[1] = b1.seed_load;
  assign in_sd[0]   = b8.seed_data;
  assign in_sd[1]   = b1.seed_data;

  task automatic cmp(input string nm, input int k,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  // Model: taps 4,3,2,0 as parity of mask 0x1D.
  function automatic logic [7:0] adv(logic [7:0] s, int n);
    for (int i = 0; i < n; i++) begin
      s = (s >> 1) | ((8'($countones(s & 8'h1D)) & 8'h01) << 7);
    end
    return s;
  endfunction

  function automatic int scan(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  int         m_steps [2] = '{8, 1};
  logic [7:0] m_s     [2];
  int         m_ptr   [2];
  int         m_w     [2];
  int         m_left  [2];
  logic [3:0] e_grant [2];
  logic [7:0] e_data  [2];
  logic       e_valid [2];
  logic       mvalid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_grant[k] = 4'b0;
      e_valid[k] = 1'b0;
      if (!rst_n) begin
        m_s[k]    = 8'hFF;
        m_ptr[k]  = 0;
        m_left[k] = 0;
        e_data[k] = 8'h00;
      end else if (m_left[k] == 0) begin
        if (in_seed[k]) begin
          m_s[k] = (in_sd[k] == 8'h00) ? 8'hFF : in_sd[k];
        end else if (|in_req[k]) begin
          m_w[k]    = scan(in_req[k], m_ptr[k]);
          m_left[k] = m_steps[k] + 1;
        end
      end else begin
        m_left[k]--;
        if (m_left[k] == 1) begin
          m_s[k]     = adv(m_s[k], m_steps[k]);
          e_grant[k] = 4'b0001 << m_w[k];
          e_valid[k] = 1'b1;
          e_data[k]  = m_s[k];
          m_ptr[k]   = (m_w[k] + 1) % 4;
        end
      end
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        cmp("grant", k, 8'(a_grant[k]), 8'(e_grant[k]));
        cmp("valid", k, 8'(a_valid[k]), 8'(e_valid[k]));
        cmp("data", k, a_data[k], e_data[k]);
        cmp("busy", k, 8'(a_busy[k]), 8'(m_left[k] > 0));
        cmp("seed_ready", k, 8'(a_ready[k]),
            8'(m_left[k] == 0));
      end
    end
  end

  task automatic wait_del(input int k,
                          output logic [3:0] g,
                          output logic [7:0] d,
                          output int bn,
                          output int cyc);
    g = 4'b0;
    d = 8'h00;
    bn = 0;
    cyc = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (a_busy[k]) bn++;
      if (a_valid[k]) begin
        g = a_grant[k];
        d = a_data[k];
        return;
      end
    end
    checks++;
    errs++;
    $display("FAIL deliver_timeout dut%0d: got none expected grant", k);
  endtask

  logic [3:0] gb_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] db_exp [5] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h87};
  logic [3:0] gc_exp [5] = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h8};

  initial begin
    logic [3:0] g;
    logic [7:0] d;
    int bn;
    int cyc;
    int first_busy;

    rst_n = 1'b0;
    b8.req = '0; b8.seed_load = 1'b0; b8.seed_data = '0;
    b1.req = '0; b1.seed_load = 1'b0; b1.seed_data = '0;
    repeat (2) @(negedge clk);
    cmp("rst_data", 0, a_data[0], 8'h00);
    cmp("rst_busy", 0, 8'(a_busy[0]), 8'h00);
    cmp("rst_ready", 1, 8'(a_ready[1]), 8'h01);
    rst_n = 1'b1;

    // STEPS=8 single request: D0 after 9 busy cycles
    @(negedge clk);
    b8.req = 4'b0001;
    @(posedge clk);
    #1;
    b8.req = 4'b0000;
    first_busy = a_busy[0] ? 1 : 0;
    wait_del(0, g, d, bn, cyc);
    cmp("a_grant", 0, 8'(g), 8'h01);
    cmp("a_data", 0, d, 8'hD0);
    cmp("a_busy_cycles", 0, 8'(first_busy + bn), 8'd9);

    // STEPS=1, all requesting: rotation and LFSR chain
    b1.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_del(1, g, d, bn, cyc);
      cmp("b_grant", 1, 8'(g), 8'(gb_exp[i]));
      cmp("b_data", 1, d, db_exp[i]);
      if (i > 0) cmp("b_period", 1, 8'(cyc), 8'd3);
    end
    b1.req = 4'b0000;

    // Fairness with two requesters, then wrap to same one
    b1.req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      wait_del(1, g, d, bn, cyc);
      cmp("c_grant", 1, 8'(g), 8'(gc_exp[i]));
      if (i == 3) b1.req = 4'b1000;
    end
    b1.req = 4'b0000;

    // Seed beats request in the same cycle
    repeat (2) @(negedge clk);
    b1.seed_load = 1'b1;
    b1.seed_data = 8'h43;
    b1.req = 4'b0001;
    @(posedge clk);
    #1;
    b1.seed_load = 1'b0;
    cmp("d_no_arb", 1, 8'(a_busy[1]), 8'h00);
    wait_del(1, g, d, bn, cyc);
    b1.req = 4'b0000;
    cmp("d_grant", 1, 8'(g), 8'h01);
    cmp("d_data", 1, d, 8'hA1);

    // Zero seed becomes FF
    repeat (2) @(negedge clk);
    b1.seed_load = 1'b1;
    b1.seed_data = 8'h00;
    @(negedge clk);
    b1.seed_load = 1'b0;
    b1.req = 4'b0001;
    wait_del(1, g, d, bn, cyc);
    b1.req = 4'b0000;
    cmp("e_data", 1, d, 8'h7F);

    // Seed during ADVANCE is ignored
    @(negedge clk);
    b8.seed_load = 1'b1;
    b8.seed_data = 8'hFF;
    @(negedge clk);
    b8.seed_load = 1'b0;
    b8.req = 4'b0010;
    @(posedge clk);
    #1;
    b8.req = 4'b0000;
    b8.seed_load = 1'b1;
    b8.seed_data = 8'h55;
    wait_del(0, g, d, bn, cyc);
    b8.seed_load = 1'b0;
    cmp("f_grant", 0, 8'(g), 8'h02);
    cmp("f_data", 0, d, 8'hD0);

    // Reset in mid-ADVANCE drops the grant
    repeat (2) @(negedge clk);
    b8.req = 4'b0001;
    @(posedge clk);
    #1;
    b8.req = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmp("g_rst_grant", 0, 8'(a_grant[0]), 8'h00);
    cmp("g_rst_valid", 0, 8'(a_valid[0]), 8'h00);
    cmp("g_rst_data", 0, a_data[0], 8'h00);
    cmp("g_rst_busy", 0, 8'(a_busy[0]), 8'h00);
    repeat (12) @(negedge clk);
    b8.req = 4'b0001;
    @(posedge clk);
    #1;
    b8.req = 4'b0000;
    wait_del(0, g, d, bn, cyc);
    cmp("g_grant", 0, 8'(g), 8'h01);
    cmp("g_data", 0, d, 8'hD0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
